// File: rtl/blink_ctr_pkg.sv
// Shared types and helpers for the multi-channel blink/PWM counter array.
// Mode encoding matches the cfg_mode field written by the host decode logic.
package blink_ctr_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_UP      = 2'b01,
        MODE_UPDOWN  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    localparam int MODE_W = 2;

    // A single channel still needs a one-bit select field.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blink_ctr_chan.sv
// One counter channel: mode/duty config, counter with direction and done,
// one-cycle wrap pulse and PWM compare output.
module blink_ctr_chan
    import blink_ctr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [WIDTH-1:0] cnt,
    output logic             blink,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = '1;

    mode_t            mode;
    logic [WIDTH-1:0] duty;
    logic             dir;
    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] dn;

    assign up = cnt + WIDTH'(1);
    assign dn = cnt - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode <= MODE_OFF;
            duty <= '0;
            cnt  <= '0;
            dir  <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else if (wr) begin
            mode <= mode_t'(cfg_mode);
            duty <= cfg_duty;
            cnt  <= '0;
            dir  <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (tick) begin
                unique case (mode)
                    MODE_OFF: cnt <= '0;
                    MODE_UP: begin
                        cnt  <= up;
                        wrap <= (cnt == MAX);
                    end
                    // dir=0 climbs toward MAX, dir=1 descends toward 0
                    MODE_UPDOWN: begin
                        if (!dir) begin
                            cnt <= up;
                            if (up == MAX) begin
                                dir  <= 1'b1;
                                wrap <= 1'b1;
                            end
                        end else begin
                            cnt <= dn;
                            if (dn == '0) begin
                                dir  <= 1'b0;
                                wrap <= 1'b1;
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        if (!done) begin
                            cnt <= up;
                            if (up == MAX) begin
                                done <= 1'b1;
                                wrap <= 1'b1;
                            end
                        end
                    end
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign blink = (mode != MODE_OFF) && (cnt < duty);

endmodule

// File: rtl/blink_ctr_array.sv
// N-channel blink/PWM counter array with a shared programmable prescaler
// and per-channel config write decode.
module blink_ctr_array
    import blink_ctr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16,
    localparam int CH_W    = ch_bits(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic [WIDTH-1:0]          cfg_duty,
    input  logic                      div_we,
    input  logic [DIV_W-1:0]          div_val,
    output logic [CHANNELS*WIDTH-1:0] cnt_o,
    output logic [CHANNELS-1:0]       blink_o,
    output logic [CHANNELS-1:0]       wrap_o,
    output logic [CHANNELS-1:0]       done_o
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pcnt;
    logic             tick;
    logic             in_range;

    // A divisor load restarts the period, so it suppresses this cycle's tick.
    assign tick = ena && !div_we && (pcnt == div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div  <= '0;
            pcnt <= '0;
        end else if (div_we) begin
            div  <= div_val;
            pcnt <= '0;
        end else if (ena) begin
            pcnt <= tick ? '0 : pcnt + DIV_W'(1);
        end
    end

    assign in_range = int'(cfg_ch) < CHANNELS;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr;

        assign wr = cfg_we && in_range && (cfg_ch == CH_W'(i));

        blink_ctr_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .wr      (wr),
            .cfg_mode(cfg_mode),
            .cfg_duty(cfg_duty),
            .cnt     (cnt_o[i*WIDTH +: WIDTH]),
            .blink   (blink_o[i]),
            .wrap    (wrap_o[i]),
            .done    (done_o[i])
        );
    end

endmodule

// File: tb/tb_blink_ctr_array.sv
// Randomized and directed bench for blink_ctr_array, checked against a
// step-count reference model of each channel and the prescaler.
module tb_blink_ctr_array;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int DIV_W    = 16;
    localparam int CH_W     = 2;
    localparam int MAXV     = (1 << WIDTH) - 1;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      ena;
    logic                      cfg_we;
    logic [CH_W-1:0]           cfg_ch;
    logic [1:0]                cfg_mode;
    logic [WIDTH-1:0]          cfg_duty;
    logic                      div_we;
    logic [DIV_W-1:0]          div_val;
    logic [CHANNELS*WIDTH-1:0] cnt_o;
    logic [CHANNELS-1:0]       blink_o;
    logic [CHANNELS-1:0]       wrap_o;
    logic [CHANNELS-1:0]       done_o;

    blink_ctr_array #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .DIV_W   (DIV_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty),
        .div_we  (div_we),
        .div_val (div_val),
        .cnt_o   (cnt_o),
        .blink_o (blink_o),
        .wrap_o  (wrap_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each channel is described by ticks seen since its last write.
    int m_mode  [CHANNELS];
    int m_duty  [CHANNELS];
    int m_steps [CHANNELS];
    bit m_wrap  [CHANNELS];
    int m_div;
    int m_since;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int exp_cnt(input int ch);
        int p;
        case (m_mode[ch])
            1: return m_steps[ch] % (MAXV + 1);
            2: begin
                p = m_steps[ch] % (2 * MAXV);
                return (p <= MAXV) ? p : 2 * MAXV - p;
            end
            3: return m_steps[ch];
            default: return 0;
        endcase
    endfunction

    task automatic model_update();
        bit t;
        int p;
        t = 1'b0;
        if (!rst_n) begin
            m_div   = 0;
            m_since = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                m_mode[c]  = 0;
                m_duty[c]  = 0;
                m_steps[c] = 0;
                m_wrap[c]  = 1'b0;
            end
            return;
        end
        if (div_we) begin
            m_div   = int'(div_val);
            m_since = 0;
        end else if (ena) begin
            m_since++;
            if (m_since == m_div + 1) begin
                t       = 1'b1;
                m_since = 0;
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            m_wrap[c] = 1'b0;
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c]  = int'(cfg_mode);
                m_duty[c]  = int'(cfg_duty);
                m_steps[c] = 0;
            end else if (t && m_mode[c] != 0) begin
                if (m_mode[c] == 3) begin
                    if (m_steps[c] < MAXV) begin
                        m_steps[c]++;
                        m_wrap[c] = (m_steps[c] == MAXV);
                    end
                end else begin
                    m_steps[c]++;
                    if (m_mode[c] == 1) begin
                        m_wrap[c] = (m_steps[c] % (MAXV + 1)) == 0;
                    end else begin
                        p = m_steps[c] % (2 * MAXV);
                        m_wrap[c] = (p == MAXV) || (p == 0);
                    end
                end
            end
        end
    endtask

    task automatic compare();
        logic [CHANNELS*WIDTH-1:0] ec;
        logic [CHANNELS-1:0] eb;
        logic [CHANNELS-1:0] ew;
        logic [CHANNELS-1:0] ed;
        int v;
        for (int c = 0; c < CHANNELS; c++) begin
            v = exp_cnt(c);
            ec[c*WIDTH +: WIDTH] = v[WIDTH-1:0];
            eb[c] = (m_mode[c] != 0) && (v < m_duty[c]);
            ew[c] = m_wrap[c];
            ed[c] = (m_mode[c] == 3) && (m_steps[c] == MAXV);
        end
        check("cnt", 64'(cnt_o), 64'(ec));
        check("blink", 64'(blink_o), 64'(eb));
        check("wrap", 64'(wrap_o), 64'(ew));
        check("done", 64'(done_o), 64'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        cfg_we = 1'b0;
        div_we = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_cfg(input int ch, input int mode, input int duty);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = WIDTH'(duty);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wr_div(input int v);
        div_we  = 1'b1;
        div_val = DIV_W'(v);
        step();
        div_we = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_mode = '0;
        cfg_duty = '0;
        div_we   = 1'b0;
        div_val  = '0;
        #2;
        step();
        rst_n = 1'b1;
        ena   = 1'b1;
        idle(3);

        // UP with duty 4 on ch0, full wrap
        wr_div(0);
        wr_cfg(0, 1, 4);
        idle(600);

        // UPDOWN on ch1 with div=3
        wr_div(3);
        wr_cfg(1, 2, 100);
        idle(2100);

        // ONESHOT on ch2, then rewrite
        wr_div(0);
        wr_cfg(2, 3, 200);
        idle(300);
        wr_cfg(2, 3, 200);
        idle(5);

        // write coincident with tick, write+div together, out-of-range
        wr_cfg(0, 1, 4);
        idle(2);
        cfg_we   = 1'b1;
        cfg_ch   = 2'd1;
        cfg_mode = 2'd1;
        cfg_duty = 8'd50;
        div_we   = 1'b1;
        div_val  = 16'd1;
        step();
        idle(6);
        wr_cfg(3, 1, 9);
        idle(4);

        // hold while disabled, writes still accepted, then mid-count reset
        ena = 1'b0;
        idle(10);
        wr_cfg(2, 2, 30);
        idle(3);
        ena = 1'b1;
        idle(8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(20);

        // randomized traffic
        wr_div(0);
        for (int i = 0; i < 4000; i++) begin
            rst_n    = ($urandom_range(0, 999) != 0);
            ena      = ($urandom_range(0, 7) != 0);
            cfg_we   = ($urandom_range(0, 19) == 0);
            cfg_ch   = CH_W'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_duty = WIDTH'($urandom());
            div_we   = ($urandom_range(0, 59) == 0);
            div_val  = DIV_W'($urandom_range(0, 3));
            step();
        end
        rst_n = 1'b1;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
